// File: rtl/axil_snn_slave.sv
// AXI4-Lite slave for the SNN coprocessor: image-buffer write path, control/status
// registers, start pulse and completion interrupt.
module axil_snn_slave #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 12,
    parameter int                        IMG_WORDS      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] IMG_BASE       = 12'h400,
    parameter int                        RESULT_WIDTH   = 8,
    localparam int                       IMG_AW         = $clog2(IMG_WORDS)
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0] WDATA,
    input  logic [3:0]                WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [AXI_DATA_WIDTH-1:0] RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    input  logic                      COPROCESSOR_RDY,
    input  logic [RESULT_WIDTH-1:0]   INFERED_DIGIT,
    output logic                      IMG_WE,
    output logic [IMG_AW-1:0]         IMG_ADDR,
    output logic [AXI_DATA_WIDTH-1:0] IMG_WDATA,
    output logic [3:0]                IMG_WSTRB,
    output logic                      START,
    output logic                      IRQ
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_ADDR_WIDTH-1:0] IMG_MASK = AXI_ADDR_WIDTH'(IMG_WORDS * 4 - 1);

    logic                      aw_held_q, w_held_q;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                wstrb_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q, bresp_d;
    logic                      img_we_q, img_we_d;
    logic [IMG_AW-1:0]         img_addr_q;
    logic [AXI_DATA_WIDTH-1:0] img_wdata_q;
    logic [3:0]                img_wstrb_q;
    logic                      start_q, start_d;
    logic                      irq_en_q, irq_en_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d, done_clr;
    logic                      irq_q, rdy_q, complete;
    logic [RESULT_WIDTH-1:0]   result_q;
    logic                      rvalid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      wr_commit, wr_is_reg, wr_is_img, rd_is_reg, ar_hs;
    logic                      unused_addr_bits;

    // Both channels are closed while a response is pending, so commit never overlaps BVALID.
    assign AWREADY   = ~aw_held_q & ~bvalid_q;
    assign WREADY    = ~w_held_q & ~bvalid_q;
    assign ARREADY   = ~rvalid_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign IMG_WE    = img_we_q;
    assign IMG_ADDR  = img_addr_q;
    assign IMG_WDATA = img_wdata_q;
    assign IMG_WSTRB = img_wstrb_q;
    assign START     = start_q;
    assign IRQ       = irq_q;

    assign wr_commit = aw_held_q & w_held_q;
    assign wr_is_reg = (awaddr_q[AXI_ADDR_WIDTH-1:4] == '0);
    assign wr_is_img = ((awaddr_q & ~IMG_MASK) == IMG_BASE);
    assign rd_is_reg = (ARADDR[AXI_ADDR_WIDTH-1:4] == '0);
    assign ar_hs     = ARVALID & ~rvalid_q;
    assign complete  = COPROCESSOR_RDY & ~rdy_q & busy_q;
    assign unused_addr_bits = ^{awaddr_q[1:0], ARADDR[1:0]};

    always_comb begin
        bresp_d  = RESP_OKAY;
        img_we_d = 1'b0;
        start_d  = 1'b0;
        done_clr = 1'b0;
        irq_en_d = irq_en_q;
        if (wr_commit) begin
            if (wr_is_reg) begin
                if (wstrb_q[0]) begin
                    case (awaddr_q[3:2])
                        2'd0: begin
                            // A refused START discards the whole CTRL write, IRQ_EN included.
                            if (wdata_q[0] && busy_q) begin
                                bresp_d = RESP_SLVERR;
                            end else begin
                                irq_en_d = wdata_q[1];
                                start_d  = wdata_q[0];
                            end
                        end
                        2'd1:    done_clr = wdata_q[1];
                        default: ;
                    endcase
                end
            end else if (wr_is_img) begin
                if (busy_q) bresp_d = RESP_SLVERR;
                else        img_we_d = 1'b1;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (start_d)       busy_d = 1'b1;
        else if (complete) busy_d = 1'b0;
        done_d = done_q;
        if (complete)                  done_d = 1'b1;
        else if (start_d || done_clr)  done_d = 1'b0;
    end

    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        if (rd_is_reg) begin
            case (ARADDR[3:2])
                2'd0:    rdata_d[1]   = irq_en_q;
                2'd1:    rdata_d[1:0] = {done_q, busy_q};
                2'd2:    rdata_d      = AXI_DATA_WIDTH'(result_q);
                default: rdata_d      = AXI_DATA_WIDTH'(IMG_WORDS);
            endcase
        end else begin
            rresp_d = RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            img_we_q    <= 1'b0;
            img_addr_q  <= '0;
            img_wdata_q <= '0;
            img_wstrb_q <= '0;
            start_q     <= 1'b0;
            irq_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            rdy_q       <= 1'b0;
            result_q    <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            if (AWVALID && AWREADY) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= AWADDR;
            end
            if (WVALID && WREADY) begin
                w_held_q <= 1'b1;
                wdata_q  <= WDATA;
                wstrb_q  <= WSTRB;
            end
            if (wr_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= bresp_d;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
            img_we_q <= img_we_d;
            if (img_we_d) begin
                img_addr_q  <= awaddr_q[IMG_AW+1:2];
                img_wdata_q <= wdata_q;
                img_wstrb_q <= wstrb_q;
            end
            start_q  <= start_d;
            irq_en_q <= irq_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            irq_q    <= done_q & irq_en_q;
            rdy_q    <= COPROCESSOR_RDY;
            if (complete) result_q <= INFERED_DIGIT;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_snn_slave.sv
// Directed bench for axil_snn_slave: stimulus tasks queue expected responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axil_snn_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [11:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [11:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        COPROCESSOR_RDY = 1'b0;
    logic [7:0]  INFERED_DIGIT = '0;
    logic        IMG_WE;
    logic [7:0]  IMG_ADDR;
    logic [31:0] IMG_WDATA;
    logic [3:0]  IMG_WSTRB;
    logic        START;
    logic        IRQ;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    int n_checks = 0;
    int n_fail = 0;
    int start_exp = 0;
    int start_seen = 0;
    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];
    logic [43:0] img_q[$];

    axil_snn_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .COPROCESSOR_RDY(COPROCESSOR_RDY), .INFERED_DIGIT(INFERED_DIGIT),
        .IMG_WE(IMG_WE), .IMG_ADDR(IMG_ADDR), .IMG_WDATA(IMG_WDATA), .IMG_WSTRB(IMG_WSTRB),
        .START(START), .IRQ(IRQ)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {AWREADY, WREADY, ARREADY, BVALID, RVALID, IMG_WE, START, IRQ, BRESP, RRESP},
              12'b1110_0000_0000);
        check({name, "_data"}, {RDATA, IMG_ADDR, IMG_WDATA, IMG_WSTRB}, '0);
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETN) begin
                if (BVALID && BREADY) begin
                    if (b_q.size() == 0) report_fail("b_unexpected");
                    else check("bresp", BRESP, b_q.pop_front());
                end
                if (RVALID && RREADY) begin
                    if (r_q.size() == 0) report_fail("r_unexpected");
                    else check("rdata_rresp", {RDATA, RRESP}, r_q.pop_front());
                end
                if (IMG_WE) begin
                    if (img_q.size() == 0) report_fail("img_we_unexpected");
                    else check("img_write", {IMG_ADDR, IMG_WDATA, IMG_WSTRB}, img_q.pop_front());
                end
                if (START) start_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_aw(input logic [11:0] a);
        bit ok = 1'b0;
        AWADDR = a;
        AWVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (AWREADY) begin ok = 1'b1; break; end
        end
        if (!ok) report_fail("aw_timeout");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        WDATA = d;
        WSTRB = s;
        WVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (WREADY) begin ok = 1'b1; break; end
        end
        if (!ok) report_fail("w_timeout");
        @(posedge ACLK); #1;
        WVALID = 1'b0;
    endtask

    task automatic wait_b(input int hold);
        bit ok = 1'b0;
        bit bad = 1'b0;
        logic [1:0] snap;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (BVALID) begin ok = 1'b1; break; end
        end
        if (!ok) begin report_fail("b_timeout"); return; end
        snap = BRESP;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge ACLK);
                if (BVALID !== 1'b1 || BRESP !== snap || AWREADY !== 1'b0 || WREADY !== 1'b0) bad = 1'b1;
            end
            check("b_hold_stable", bad, 1'b0);
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    // w_lead > 0: W is issued that many cycles before AW.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input logic [1:0] resp, input int img_idx,
                             input bit exp_start, input int hold, input bit edge_at_commit);
        logic [7:0] idx = img_idx[7:0];
        b_q.push_back(resp);
        if (img_idx >= 0) img_q.push_back({idx, data, strb});
        if (exp_start) start_exp++;
        fork
            begin
                if (w_lead > 0) begin repeat (w_lead) @(posedge ACLK); #1; end
                send_aw(addr);
            end
            send_w(data, strb);
        join
        if (edge_at_commit) COPROCESSOR_RDY = 1'b1;
        wait_b(hold);
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold);
        bit ok = 1'b0;
        bit bad = 1'b0;
        logic [33:0] snap;
        r_q.push_back({exp_data, exp_resp});
        ARADDR = addr;
        ARVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (ARREADY) begin ok = 1'b1; break; end
        end
        if (!ok) report_fail("ar_timeout");
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (RVALID) begin ok = 1'b1; break; end
        end
        if (!ok) begin report_fail("r_timeout"); return; end
        snap = {RDATA, RRESP};
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge ACLK);
                if (RVALID !== 1'b1 || {RDATA, RRESP} !== snap || ARREADY !== 1'b0) bad = 1'b1;
            end
            check("r_hold_stable", bad, 1'b0);
        end
        @(posedge ACLK); #1;
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge ACLK); #1;
        check_reset_outputs("reset");
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // 1: image writes, same-cycle and W-before-AW
        axi_write(12'h7FC, 32'hDEADBEEF, 4'hF, 0, OKAY, 255, 1'b0, 0, 1'b0);
        axi_write(12'h404, 32'h0BADF00D, 4'hF, 3, OKAY, 1, 1'b0, 0, 1'b0);

        // 2: start, refused start, refused image write, completion
        axi_write(12'h000, 32'h3, 4'hF, 0, OKAY, -1, 1'b1, 0, 1'b0);
        axi_read(12'h004, 32'h1, OKAY, 0);
        axi_write(12'h000, 32'h1, 4'hF, 0, SLVERR, -1, 1'b0, 0, 1'b0);
        axi_write(12'h408, 32'h11111111, 4'hF, 0, SLVERR, -1, 1'b0, 0, 1'b0);
        INFERED_DIGIT = 8'd7;
        COPROCESSOR_RDY = 1'b1;
        @(posedge ACLK); #1;
        check("irq_lag", IRQ, 1'b0);
        @(posedge ACLK); #1;
        check("irq_set", IRQ, 1'b1);
        COPROCESSOR_RDY = 1'b0;
        axi_read(12'h004, 32'h2, OKAY, 0);
        axi_read(12'h008, 32'h7, OKAY, 0);

        // 3: DONE set beats W1C in the same cycle, then W1C alone
        axi_write(12'h000, 32'h3, 4'hF, 0, OKAY, -1, 1'b1, 0, 1'b0);
        INFERED_DIGIT = 8'd9;
        axi_write(12'h004, 32'h2, 4'hF, 0, OKAY, -1, 1'b0, 0, 1'b1);
        COPROCESSOR_RDY = 1'b0;
        axi_read(12'h004, 32'h2, OKAY, 0);
        check("irq_after_race", IRQ, 1'b1);
        axi_write(12'h004, 32'h2, 4'hF, 0, OKAY, -1, 1'b0, 0, 1'b0);
        axi_read(12'h004, 32'h0, OKAY, 0);
        repeat (2) @(posedge ACLK); #1;
        check("irq_cleared", IRQ, 1'b0);

        // 4: back-pressure on B and R
        axi_write(12'h410, 32'hA5A50F0F, 4'hF, 0, OKAY, 4, 1'b0, 10, 1'b0);
        axi_read(12'h008, 32'h9, OKAY, 10);

        // 5: INFO, unmapped and image-region reads, unmapped write, strobe gating
        axi_read(12'h00C, 32'd256, OKAY, 0);
        axi_read(12'h400, 32'h0, SLVERR, 0);
        axi_read(12'h010, 32'h0, SLVERR, 0);
        axi_write(12'h800, 32'hCAFEF00D, 4'hF, 0, SLVERR, -1, 1'b0, 0, 1'b0);
        axi_read(12'h000, 32'h2, OKAY, 0);
        axi_write(12'h000, 32'h1, 4'hE, 0, OKAY, -1, 1'b0, 0, 1'b0);
        axi_read(12'h004, 32'h0, OKAY, 0);
        axi_write(12'h008, 32'hFF, 4'hF, 0, OKAY, -1, 1'b0, 0, 1'b0);
        axi_read(12'h008, 32'h9, OKAY, 0);

        // 6: asynchronous reset with a response pending and the core busy
        axi_write(12'h000, 32'h3, 4'hF, 0, OKAY, -1, 1'b1, 0, 1'b0);
        fork
            send_aw(12'h40C);
            send_w(32'h55, 4'hF);
        join
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge ACLK);
                if (BVALID) begin ok = 1'b1; break; end
            end
            if (!ok) report_fail("t6_b_timeout");
        end
        check("t6_pending_bresp", BRESP, SLVERR);
        @(negedge ACLK); #2;
        ARESETN = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        axi_write(12'h408, 32'h12345678, 4'h3, 0, OKAY, 2, 1'b0, 0, 1'b0);
        axi_read(12'h004, 32'h0, OKAY, 0);
        axi_read(12'h000, 32'h0, OKAY, 0);

        repeat (3) @(posedge ACLK); #1;
        check("start_pulses", start_seen, start_exp);
        check("b_left", b_q.size(), 0);
        check("r_left", r_q.size(), 0);
        check("img_left", img_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_snn_slave.md
Name: axil_snn_slave

Overview:
- Single AXI4-Lite slave that replaces the split write/read front-ends of the SNN coprocessor.
- Owns the image-buffer write path, a control/status register file and a completion interrupt.
- Sits between the processor interconnect and the SNN core: streams image words to the core's buffer, issues START and captures the inferred class.
- Image depth, result width and region base are parametrised.

Parameters:
AXI_DATA_WIDTH, 32, data bus width; fixed at 32 for this generation.
AXI_ADDR_WIDTH, 12, byte-address bits decoded; upper address bits are ignored.
IMG_WORDS, 256, image buffer depth in 32-bit words; power of two, 16 to 1024.
IMG_BASE, 12'h400, byte base of the image region; aligned to IMG_WORDS*4.
RESULT_WIDTH, 8, width of INFERED_DIGIT.

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
AWADDR  in  AXI_ADDR_WIDTH  write address
AWVALID / AWREADY  in / out  1  write-address handshake
WDATA  in  32  write data
WSTRB  in  4  byte strobes
WVALID / WREADY  in / out  1  write-data handshake
BRESP  out  2  write response
BVALID / BREADY  out / in  1  write-response handshake
ARADDR  in  AXI_ADDR_WIDTH  read address
ARVALID / ARREADY  in / out  1  read-address handshake
RDATA  out  32  read data
RRESP  out  2  read response
RVALID / RREADY  out / in  1  read-data handshake
COPROCESSOR_RDY  in  1  core idle/done level
INFERED_DIGIT  in  RESULT_WIDTH  core result, valid while COPROCESSOR_RDY is high
IMG_WE  out  1  one-cycle image write strobe
IMG_ADDR  out  clog2(IMG_WORDS)  image word index
IMG_WDATA  out  32  image write data
IMG_WSTRB  out  4  image byte enables
START  out  1  one-cycle inference start pulse
IRQ  out  1  level interrupt

Behaviour:
- Reset:
  - AWREADY, WREADY, ARREADY = 1.
  - BVALID, RVALID, IMG_WE, START, IRQ = 0.
  - BRESP, RRESP, RDATA, IMG_* = 0.
  - CTRL, STATUS, RESULT = 0; the COPROCESSOR_RDY edge register = 0.
  - Reset mid-transaction abandons the transaction; the master must restart it.
- Address map (byte addresses; ADDR[1:0] ignored):
  - 0x000 CTRL: bit0 START, write-1 pulse, reads 0; bit1 IRQ_EN, RW.
  - 0x004 STATUS: bit0 BUSY, read-only; bit1 DONE, sticky, write-1-to-clear.
  - 0x008 RESULT: RO, zero-extended.
  - 0x00C INFO: RO, returns IMG_WORDS.
  - IMG_BASE to IMG_BASE+IMG_WORDS*4-1: image region, write-only.
  - Any other address: unmapped, SLVERR (2'b10).
- Write channel:
  - AW and W are accepted independently, in either order or the same cycle.
  - AWREADY drops after the AW beat is captured; WREADY drops after the W beat is captured.
  - The cycle after both are held, the write commits and BVALID rises.
  - BVALID and BRESP stay stable until BREADY; both READYs return to 1 the cycle after the B handshake.
  - A new write is never accepted while BVALID is high.
- Image write commit:
  - IMG_WE=1 for exactly the commit cycle; IMG_ADDR = (addr-IMG_BASE)>>2; IMG_WDATA=WDATA; IMG_WSTRB=WSTRB.
  - If BUSY=1: no IMG_WE, SLVERR.
- Register write commit:
  - Only WSTRB[0] lanes apply; WSTRB[0]=0 means no effect, OKAY.
  - Writes to RESULT/INFO: ignored, OKAY.
  - START=1 while BUSY=0: START pulses 1 cycle in the commit cycle, BUSY<=1, DONE<=0.
  - START=1 while BUSY=1: ignored, SLVERR.
- Read channel:
  - ARREADY=1 while RVALID=0.
  - After an AR handshake, RVALID rises the next cycle with the RDATA/RRESP snapshot; held until RREADY; ARREADY=0 meanwhile.
  - Image-region or unmapped reads: RDATA=0, SLVERR.
- Reads and writes are fully independent and may complete in the same cycle.
- Completion:
  - COPROCESSOR_RDY is registered; a rising edge while BUSY=1 causes BUSY<=0, DONE<=1, RESULT<=INFERED_DIGIT.
  - Edges while BUSY=0 are ignored.
  - DONE set and DONE W1C in the same cycle: set wins.
  - IRQ = DONE & IRQ_EN, registered (1-cycle lag).

Test Plan:
1. AW and W in the same cycle to 0x400+4*255, WDATA=0xDEADBEEF, WSTRB=0xF -> IMG_WE 1 cycle, IMG_ADDR=255, IMG_WDATA=0xDEADBEEF, BRESP=OKAY; then W 3 cycles before AW to 0x404 -> IMG_ADDR=1, one B response.
2. Write CTRL=0x3 -> START 1 pulse, BUSY=1; second CTRL=0x1 -> SLVERR, no pulse; image write -> SLVERR, no IMG_WE; COPROCESSOR_RDY rises with INFERED_DIGIT=7 -> STATUS reads 0x2, RESULT reads 7, IRQ=1 one cycle later.
3. Write STATUS=0x2 in the same cycle as a completion edge -> DONE stays 1; repeat with no edge -> DONE=0, IRQ=0.
4. BREADY held low 10 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0, no second IMG_WE; RREADY held low -> RDATA/RRESP stable.
5. Read 0x00C -> 256; read 0x400 and 0x010 -> RDATA=0, SLVERR; write 0x800 -> SLVERR, no IMG_WE.
6. Assert ARESETN low while BVALID=1 and BUSY=1 -> all outputs return to their reset values asynchronously; the next write completes normally.
